// File: rtl/cla_slice_sequencer.sv
// Multi-cycle adder controller: feeds an external combinational 2-bit PG/sum slice
// one operand pair per cycle (LSB pair first), resolves the pair carries and accumulates the sum.
module cla_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       sl_a,
  output logic [1:0]       sl_b,
  output logic             sl_cin,
  output logic             sl_c0,
  input  logic [1:0]       sl_p,
  input  logic [1:0]       sl_g,
  input  logic [1:0]       sl_s
);

  localparam int STEPS = WIDTH / 2;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [SW-1:0]    step_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] opa_reg, opb_reg;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, ovf_reg;
  logic             run, last, accept, c2;
  logic [1:0]       a_pair [STEPS];
  logic [1:0]       b_pair [STEPS];

  // Per-pair views of the latched operands; the active pair of sum takes the slice result.
  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_pair
      assign a_pair[gi] = opa_reg[2*gi +: 2];
      assign b_pair[gi] = opb_reg[2*gi +: 2];
      assign sum_next[2*gi +: 2] = (step_reg == SW'(gi)) ? sl_s : sum_reg[2*gi +: 2];
    end
  endgenerate

  assign run    = (state_reg == RUN);
  assign last   = (step_reg == SW'(STEPS - 1));
  assign accept = start && !run;

  assign ready = !run;
  assign busy  = run;
  assign done  = (state_reg == DONE);
  assign sum   = sum_reg;
  assign cout  = cout_reg;
  assign ovf   = ovf_reg;

  // Slice carries come from p/g, which depend only on sl_a/sl_b, so there is no loop.
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_cin = 1'b0;
    sl_c0  = 1'b0;
    if (run) begin
      sl_a   = a_pair[step_reg];
      sl_b   = b_pair[step_reg];
      sl_cin = carry_reg;
      sl_c0  = sl_g[0] | (sl_p[0] & carry_reg);
    end
    c2 = sl_g[1] | (sl_p[1] & sl_c0);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      carry_reg <= 1'b0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        opa_reg   <= op_a;
        opb_reg   <= op_b;
        carry_reg <= op_cin;
        step_reg  <= '0;
        sum_reg   <= '0;
      end else if (run) begin
        sum_reg   <= sum_next;
        carry_reg <= c2;
        step_reg  <= step_reg + SW'(1);
        if (last) begin
          cout_reg <= c2;
          ovf_reg  <= sl_c0 ^ c2;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Directed bench for cla_slice_sequencer with a behavioural 2-bit PG/sum slice and a result scoreboard.
module tb_cla_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, op_cin;
  logic [15:0] op_a, op_b;
  logic        ready, busy, done, cout, ovf, sl_cin, sl_c0;
  logic [15:0] sum;
  logic [1:0]  sl_a, sl_b, sl_p, sl_g, sl_s;

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        cout, ovf;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   edges;

  always #5 clk = ~clk;

  cla_slice_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin), .sl_c0(sl_c0),
    .sl_p(sl_p), .sl_g(sl_g), .sl_s(sl_s)
  );

  // Reference slice
  assign sl_p = sl_a ^ sl_b;
  assign sl_g = sl_a & sl_b;
  assign sl_s = {sl_p[1] ^ sl_c0, sl_p[0] ^ sl_cin};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Carry into bit i of a+b+cin.
  function automatic logic carry_into(input logic [15:0] a, b, input logic cin, input int i);
    int unsigned m;
    m = (32'd1 << i) - 1;
    return 1'(((int'(a) & m) + (int'(b) & m) + int'(cin)) >> i);
  endfunction

  function automatic exp_t model(input logic [15:0] a, b, input logic cin);
    exp_t e;
    int unsigned full;
    full    = int'(a) + int'(b) + int'(cin);
    e.a     = a;
    e.b     = b;
    e.cin   = cin;
    e.sum   = full[15:0];
    e.cout  = full[16];
    e.ovf   = carry_into(a, b, cin, 15) ^ full[16];
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("add %h + %h + %b -> sum=%h cout=%b ovf=%b", e.a, e.b, e.cin, sum, cout, ovf);
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
      end
    end
  end

  // Call away from the rising edge; the next rising edge is the accepting edge.
  task automatic accept(input logic [15:0] a, b, input logic cin);
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    op_cin = cin;
    sb.push_back(model(a, b, cin));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) until done is seen.
  task automatic wait_done(input bit chk_steps, input int inject,
                           input logic [15:0] a, b, input logic cin, output int n);
    int k;
    exp_t e;
    e = model(a, b, cin);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      k = n - 1;
      chk("busy_in_run", {busy, ready}, 2'b10);
      if (chk_steps) begin
        chk("sl_a", sl_a, a[2*k +: 2]);
        chk("sl_b", sl_b, b[2*k +: 2]);
        chk("sl_cin", sl_cin, carry_into(a, b, cin, 2*k));
        chk("sl_c0", sl_c0, carry_into(a, b, cin, 2*k + 1));
        chk("sum_partial", sum, int'(e.sum) & ((32'd1 << (2*k)) - 1));
      end
      if (k == inject) begin
        start = 1'b1; op_a = ~a; op_b = 16'h1111; op_cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_latency", n, 9);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    #2;
    chk("reset_ready", ready, 1);
    chk("reset_busy_done", {busy, done}, 0);
    chk("reset_result", {sum, cout, ovf}, 0);
    chk("reset_sl", {sl_a, sl_b, sl_cin, sl_c0}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    accept(16'h00FF, 16'h0001, 1'b0);
    wait_done(1'b0, -1, 16'h00FF, 16'h0001, 1'b0, edges);
    @(negedge clk);
    chk("done_pulse", {done, ready}, 2'b01);
    chk("sum_hold", sum, 16'h0100);

    accept(16'hFFFF, 16'h0001, 1'b0);
    wait_done(1'b0, -1, 16'hFFFF, 16'h0001, 1'b0, edges);
    @(negedge clk);
    accept(16'h7FFF, 16'h0001, 1'b0);
    wait_done(1'b0, -1, 16'h7FFF, 16'h0001, 1'b0, edges);
    @(negedge clk);
    chk("ovf_hold_idle", {cout, ovf}, 2'b01);

    accept(16'h1234, 16'h4321, 1'b1);
    wait_done(1'b1, -1, 16'h1234, 16'h4321, 1'b1, edges);
    @(negedge clk);

    // start pulsed mid-run must not disturb the add in flight
    accept(16'h0F0F, 16'h00F1, 1'b0);
    wait_done(1'b0, 3, 16'h0F0F, 16'h00F1, 1'b0, edges);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_done", {done, busy}, 0);
    end
    chk("sb_empty_after_ignore", sb.size(), 0);

    // back-to-back: start high during DONE
    accept(16'hA5A5, 16'h5A5A, 1'b1);
    wait_done(1'b0, -1, 16'hA5A5, 16'h5A5A, 1'b1, edges);
    accept(16'h8000, 16'h8000, 1'b0);
    wait_done(1'b1, -1, 16'h8000, 16'h8000, 1'b0, edges);
    @(negedge clk);

    // reset asserted on RUN cycle 4
    accept(16'h1111, 16'h2222, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {ready, busy, done}, 3'b100);
    chk("abort_result", {sum, cout, ovf}, 0);
    chk("abort_sl", {sl_a, sl_b, sl_cin, sl_c0}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept(16'hABCD, 16'h1234, 1'b1);
    wait_done(1'b1, -1, 16'hABCD, 16'h1234, 1'b1, edges);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
